// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: RISC-V funct3 codes, FSM state
// encoding and the request legality check used at accept time.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_WRITE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_RESP   = 3'd5
   } lsu_state_e;

   // Funct3 legality plus natural alignment; the range check lives in the top
   // because it depends on the memory depth.
   function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
      logic illegal;
      logic misaligned;
      illegal    = we ? (f3 > F3_SW) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      misaligned = (f3[1:0] == 2'b01 && off[0]) ||
                   (f3[1:0] == 2'b10 && off != 2'b00);
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data_memory port bundle for the LSU.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the requester may drop or change its fields after that edge. resp_valid is a
// one-cycle pulse with no backpressure; resp_rdata/resp_err are valid with it.
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 16,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              mem_wEn;
   logic [MEM_AW-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   // Requester side, which also models data_memory.
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_wEn, mem_address, mem_write_data
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_wEn, mem_address, mem_write_data
   );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: load byte/halfword extract with sign/zero extension,
// and store lane merge of right-aligned write data into a word read back from memory.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b    = rdata[{byte_off, 3'b000} +: 8];
      lane_h    = byte_off[1] ? rdata[31:16] : rdata[15:0];
      load_data = '0;
      case (funct3)
         F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         F3_LW:   load_data = rdata;
         F3_LBU:  load_data = {24'd0, lane_b};
         F3_LHU:  load_data = {16'd0, lane_h};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      merged = rdata;
      case (funct3)
         F3_SB:   merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
         F3_SH: begin
            if (byte_off[1]) merged[31:16] = wdata[15:0];
            else             merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-wide data_memory with a
// single write enable; sub-word stores go through a read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 16,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   bus,
   output lsu_state_e         state_dbg
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MEM_AW-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_wen_q, mem_wen_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              accept;
   logic              req_err;
   logic [ADDR_W-1:0] addr_hi;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged;

   lsu_align u_align (
      .funct3    (f3_q),
      .byte_off  (off_q),
      .rdata     (bus.mem_read_data),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   assign accept  = bus.req_valid && req_ready_q;
   assign addr_hi = bus.req_addr >> (MEM_AW + 2);
   assign req_err = req_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) ||
                    (addr_hi != '0);

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      f3_d          = f3_q;
      off_d         = off_q;
      wdata_d       = wdata_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      resp_rdata_d  = resp_rdata_q;
      resp_err_d    = resp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d         = bus.req_we;
               f3_d         = bus.req_funct3;
               off_d        = bus.req_addr[1:0];
               wdata_d      = bus.req_wdata;
               resp_rdata_d = '0;
               resp_err_d   = req_err;
               if (req_err) begin
                  state_d = S_RESP;
               end else begin
                  // Address is left untouched on errors so memory never sees them.
                  mem_address_d = bus.req_addr[MEM_AW+1:2];
                  if (!bus.req_we) begin
                     state_d = S_LOAD;
                  end else if (bus.req_funct3 == F3_SW) begin
                     state_d     = S_WRITE;
                     mem_wdata_d = bus.req_wdata;
                  end else begin
                     state_d = S_RMW_RD;
                  end
               end
            end
         end
         S_LOAD: begin
            resp_rdata_d = load_data;
            state_d      = S_RESP;
         end
         S_WRITE:  state_d = S_RESP;
         S_RMW_RD: begin
            mem_wdata_d = merged;
            state_d     = S_RMW_WR;
         end
         S_RMW_WR: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      mem_wen_d    = (state_d == S_WRITE) || (state_d == S_RMW_WR);
      resp_valid_d = (state_d == S_RESP);
      req_ready_d  = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         we_q          <= 1'b0;
         f3_q          <= '0;
         off_q         <= '0;
         wdata_q       <= '0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_wen_q     <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         f3_q          <= f3_d;
         off_q         <= off_d;
         wdata_q       <= wdata_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_wen_q     <= mem_wen_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_err_q    <= resp_err_d;
      end
   end

   assign bus.req_ready      = req_ready_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_rdata     = resp_rdata_q;
   assign bus.resp_err       = resp_err_q;
   assign bus.mem_wEn        = mem_wen_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_write_data = mem_wdata_q;
   assign state_dbg          = state_q;

   // we_q is kept for debug visibility of the captured request direction.
   logic unused_ok;
   assign unused_ok = we_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and `data_memory`, translating RISC-V byte-addressed loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's single write-enable port. Sub-word stores use a read-modify-write sequence because `data_memory` has no byte enables. Loads are extracted and sign- or zero-extended. Misaligned or out-of-range requests are flagged without touching memory. Requests use a valid/ready handshake; responses are a single-cycle pulse.

## Interface
- `ADDR_W`, 32: byte-address width from the execute stage.
- `MEM_AW`, 16: word-address width of `data_memory`.
- `DATA_W`, 32: data width, fixed at 32.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (load 0,1,2,4,5; store 0,1,2).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal funct3, or out of range; valid with `resp_valid`.
- `mem_wEn`  out  1  to `data_memory.mem_wEn`.
- `mem_address`  out  MEM_AW  word index, = byte_addr[MEM_AW+1:2].
- `mem_write_data`  out  DATA_W  to `data_memory.write_data`.
- `mem_read_data`  in  DATA_W  from `data_memory.read_data`; combinational on `mem_address`.

## Operation
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- **Accept:** on `req_valid && req_ready` at a rising edge. Capture `req_we`, `req_funct3`, `req_addr` and `req_wdata`. Upstream may change its inputs after the edge.
- **Error check (at accept):**
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Illegal funct3: loads 3/6/7, stores ≥3.
  - addr[ADDR_W-1:MEM_AW+2]≠0.
  - On error: go to RESP with `resp_err`=1 and `resp_rdata`=0. `mem_wEn` is never asserted.
- **LOAD:** drive `mem_address`. At the edge, select the byte (addr[1:0]) or halfword (addr[1]) and extend it: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Then go to RESP.
- **SW:** IDLE→WRITE with `mem_wEn`=1 for exactly one cycle and `mem_write_data`=wdata, then RESP.
- **SB/SH:**
  - IDLE→RMW_RD: read the word; at the edge, merge wdata[7:0] or wdata[15:0] into the selected lane of a buffer register.
  - RMW_RD→RMW_WR: `mem_wEn`=1 for one cycle with the merged word.
  - Then RESP.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE. No response backpressure.
- **Registered outputs:** `mem_address` and `mem_write_data` are registered and hold their last value in IDLE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wEn`=0, `mem_address`=0, `mem_write_data`=0.
- Latency, counted as cycles from the accept edge to the `resp_valid` cycle:
  - Load / SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Throughput: one request per 3 (load/SW), 4 (SB/SH) or 2 (error) cycles. `req_ready` is low from the cycle after accept until the cycle after RESP.
- Reset mid-operation takes effect asynchronously:
  - `mem_wEn` drops immediately.
  - Reset before the RMW_WR edge leaves memory unchanged.
  - No `resp_valid` is produced for the aborted request.
- `mem_wEn` is asserted only in WRITE and RMW_WR, never two consecutive cycles.

## Structure
- Package `lsu_pkg`: funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2) and the state encoding.
- Sub-module `lsu_align`: combinational load extract/extend and store lane merge, instantiated once.

## Test plan
- Preload word 0x6f = 0x11100011; LW addr 0x1BC → `resp_rdata`=0x11100011, `resp_err`=0, `resp_valid` 2 cycles after accept.
- Word 0x6f = 0x80FF7F01:
  - LB 0x1BF → 0xFFFFFF80.
  - LBU 0x1BF → 0x00000080.
  - LH 0x1BE → 0xFFFF80FF.
  - LHU 0x1BE → 0x000080FF.
- Word 0x6f = 0x11100011; SB 0x1BD wdata 0x000000AA → memory 0x1110AA11, `mem_wEn` high exactly one cycle, `resp_valid` 3 cycles after accept.
- SH 0x1BD, LW 0x1BE and LH 0x40000 → `resp_err`=1, `resp_rdata`=0, `mem_wEn` never high, memory unchanged.
- SB issued, `rst` pulled low during RMW_RD → all outputs at reset values immediately, memory word unchanged, `req_ready`=1 after release.
- Back-to-back SW 0x1BC 0xDEADBEEF then LW 0x1BC → 0xDEADBEEF; `req_valid` held high is accepted only when `req_ready`=1.
